// File: rtl/sample_rate_handoff.sv
// Single-clock frame FIFO that releases multi-channel DSP frames on a fixed-rate
// strobe from an integer divider, with sticky overflow/underflow flags.
module sample_rate_handoff #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned DIV           = 8,
  parameter int unsigned ZERO_ON_EMPTY = 0
) (
  input  logic                         Clk,
  input  logic                         Rst_N,
  input  logic [CHANNELS*WIDTH-1:0]    Data_In,
  input  logic                         Valid_In,
  input  logic                         Clear_Flags,
  output logic [CHANNELS*WIDTH-1:0]    Data_Out,
  output logic                         Valid_Out,
  output logic                         Tick,
  output logic [$clog2(DEPTH+1)-1:0]   Fill,
  output logic                         Overflow,
  output logic                         Underflow
);

  localparam int unsigned FRAME_W = CHANNELS * WIDTH;
  localparam int unsigned FW      = $clog2(DEPTH + 1);
  localparam int unsigned PW      = $clog2(DEPTH);
  localparam int unsigned CW      = $clog2(DIV);

  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [FW-1:0]      r_fill;
  logic [FRAME_W-1:0] r_mem [DEPTH];
  logic [FRAME_W-1:0] r_data_out;
  logic               r_valid_out;
  logic               r_tick;
  logic               r_overflow;
  logic               r_underflow;

  logic w_s;
  logic w_full;
  logic w_empty;
  logic w_wr;
  logic w_rd;
  logic w_drop;
  logic w_under;

  // A full FIFO still accepts a write on a strobe because the read frees a slot.
  always_comb begin
    w_s     = (r_cnt == CW'(DIV - 1));
    w_full  = (r_fill == FW'(DEPTH));
    w_empty = (r_fill == '0);
    w_rd    = w_s && !w_empty;
    w_under = w_s && w_empty;
    w_wr    = Valid_In && (!w_full || w_s);
    w_drop  = Valid_In && w_full && !w_s;
  end

  // Output-rate divider
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_s ? '0 : r_cnt + CW'(1);
      r_tick <= w_s;
    end
  end

  // Frame storage is intentionally not reset
  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= Data_In;
  end

  // Pointers, fill count and registered output frame
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= w_rd;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        r_data_out <= r_mem[r_rd_ptr];
      end else if (w_under && (ZERO_ON_EMPTY != 0)) begin
        r_data_out <= '0;
      end
      case ({w_wr, w_rd})
        2'b10:   r_fill <= r_fill + FW'(1);
        2'b01:   r_fill <= r_fill - FW'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // Sticky flags; a new event wins over a same-cycle clear
  always_ff @(posedge Clk or negedge Rst_N) begin
    if (!Rst_N) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_drop)           r_overflow <= 1'b1;
      else if (Clear_Flags) r_overflow <= 1'b0;
      if (w_under)          r_underflow <= 1'b1;
      else if (Clear_Flags) r_underflow <= 1'b0;
    end
  end

  assign Data_Out  = r_data_out;
  assign Valid_Out = r_valid_out;
  assign Tick      = r_tick;
  assign Fill      = r_fill;
  assign Overflow  = r_overflow;
  assign Underflow = r_underflow;

endmodule

// File: tb/tb_sample_rate_handoff.sv
// Scoreboard bench for sample_rate_handoff: directed frames are queued as they are
// written and a monitor pops them whenever Valid_Out is seen.
module tb_sample_rate_handoff;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CHANNELS = 2;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned DIV      = 8;
  localparam int unsigned FW       = $clog2(DEPTH + 1);
  localparam int unsigned FRAME_W  = CHANNELS * WIDTH;

  logic               clk;
  logic               rst_n;
  logic [FRAME_W-1:0] data_in;
  logic               valid_in;
  logic               clear_flags;

  logic [FRAME_W-1:0] h_data, z_data;
  logic               h_valid, z_valid, h_tick, z_tick;
  logic [FW-1:0]      h_fill, z_fill;
  logic               h_ovf, z_ovf, h_unf, z_unf;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt;
  logic [FRAME_W-1:0] exp_q [$];

  sample_rate_handoff #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .DIV(DIV),
                        .ZERO_ON_EMPTY(0)) u_hold (
    .Clk(clk), .Rst_N(rst_n), .Data_In(data_in), .Valid_In(valid_in),
    .Clear_Flags(clear_flags), .Data_Out(h_data), .Valid_Out(h_valid), .Tick(h_tick),
    .Fill(h_fill), .Overflow(h_ovf), .Underflow(h_unf));

  sample_rate_handoff #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .DIV(DIV),
                        .ZERO_ON_EMPTY(1)) u_zero (
    .Clk(clk), .Rst_N(rst_n), .Data_In(data_in), .Valid_In(valid_in),
    .Clear_Flags(clear_flags), .Data_Out(z_data), .Valid_Out(z_valid), .Tick(z_tick),
    .Fill(z_fill), .Overflow(z_ovf), .Underflow(z_unf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference divider: strobe is due in the cycle where m_cnt == DIV-1
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 0;
    else        m_cnt <= (m_cnt == int'(DIV) - 1) ? 0 : m_cnt + 1;
  end

  function automatic logic [FRAME_W-1:0] fr(input logic [15:0] c0, input logic [15:0] c1);
    return {c1, c0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to the negedge inside the next strobe cycle
  task automatic wait_s_cycle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (m_cnt != int'(DIV) - 1 && k < 2 * int'(DIV));
    if (m_cnt != int'(DIV) - 1) chk("strobe_timeout", 32'(k), 32'(DIV));
  endtask

  task automatic write_frame(input logic [FRAME_W-1:0] f, input bit expect_out);
    data_in  = f;
    valid_in = 1'b1;
    if (expect_out) exp_q.push_back(f);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Monitor: every Valid_Out pops the next expected frame
  always @(posedge clk) begin
    #1;
    if (h_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got %h expected no output", h_data);
      end else begin
        logic [FRAME_W-1:0] e;
        e = exp_q.pop_front();
        chk("out_frame_hold", h_data, e);
        chk("out_frame_zero", z_data, e);
        chk("out_valid_zero", 32'(z_valid), 32'd1);
      end
    end
  end

  initial begin
    int first_tick;
    int k;
    rst_n       = 1'b0;
    valid_in    = 1'b1;
    clear_flags = 1'b0;
    data_in     = FRAME_W'($urandom);

    // Reset: writes ignored, all outputs zero
    repeat (3) begin
      @(negedge clk);
      data_in = FRAME_W'($urandom);
    end
    chk("rst_data",  h_data, '0);
    chk("rst_valid", 32'(h_valid), 32'd0);
    chk("rst_tick",  32'(h_tick), 32'd0);
    chk("rst_fill",  32'(h_fill), 32'd0);
    chk("rst_flags", {30'd0, h_ovf, h_unf}, 32'd0);
    valid_in = 1'b0;
    rst_n    = 1'b1;

    // First Tick follows the DIV-th edge after release
    first_tick = 0;
    for (int i = 1; i <= 2 * int'(DIV); i++) begin
      @(posedge clk);
      #1;
      if (h_tick && first_tick == 0) first_tick = i;
    end
    chk("first_tick_edge", 32'(first_tick), 32'(DIV));

    // Ordered transfer of three frames
    wait_s_cycle();
    @(negedge clk);
    write_frame(fr(16'h0001, 16'h1001), 1'b1);
    write_frame(fr(16'h0002, 16'h1002), 1'b1);
    write_frame(fr(16'h0003, 16'h1003), 1'b1);
    chk("ordered_fill3", 32'(h_fill), 32'd3);
    for (int i = 0; i < 3; i++) begin
      wait_s_cycle();
      @(negedge clk);
      chk("ordered_valid", 32'(h_valid), 32'd1);
      chk("ordered_fill",  32'(h_fill), 32'(2 - i));
    end

    // Ten-frame burst from the cycle after a strobe: the mid-burst strobe drains
    // frame 1, frame 9 fills the last slot and frame 10 is dropped
    for (int i = 1; i <= 10; i++)
      write_frame(fr(16'(16'h0100 + i), 16'(16'h1100 + i)), i <= 9);
    chk("burst_fill8",    32'(h_fill), 32'(DEPTH));
    chk("burst_overflow", 32'(h_ovf), 32'd1);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("clear_overflow",  32'(h_ovf), 32'd0);
    chk("clear_underflow", 32'(h_unf), 32'd0);

    // Full FIFO with a write in the strobe cycle: accepted, no overflow
    wait_s_cycle();
    write_frame(fr(16'hABCD, 16'h1234), 1'b1);
    chk("full_strobe_fill",  32'(h_fill), 32'(DEPTH));
    chk("full_strobe_ovf",   32'(h_ovf), 32'd0);
    chk("full_strobe_valid", 32'(h_valid), 32'd1);

    // Drain, then check the empty-strobe policy on both variants
    k = 0;
    while (h_fill != '0 && k < 12 * int'(DIV)) begin
      @(negedge clk);
      k++;
    end
    chk("drain_fill", 32'(h_fill), 32'd0);
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    chk("pre_under_flag", 32'(h_unf), 32'd0);
    wait_s_cycle();
    @(negedge clk);
    chk("under_flag",       32'(h_unf), 32'd1);
    chk("under_valid",      32'(h_valid), 32'd0);
    chk("under_hold_data",  h_data, fr(16'hABCD, 16'h1234));
    chk("under_zero_data",  z_data, '0);
    chk("under_zero_flag",  32'(z_unf), 32'd1);

    // Write coinciding with a strobe on an empty FIFO: no fall-through
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    wait_s_cycle();
    write_frame(fr(16'h0C0C, 16'h1C1C), 1'b1);
    chk("coinc_valid", 32'(h_valid), 32'd0);
    chk("coinc_under", 32'(h_unf), 32'd1);
    chk("coinc_fill",  32'(h_fill), 32'd1);
    wait_s_cycle();
    @(negedge clk);
    chk("coinc_next_valid", 32'(h_valid), 32'd1);

    // Reset mid-stream with five frames buffered: nothing of them survives
    for (int i = 0; i < 5; i++)
      write_frame(fr(16'(16'h0500 + i), 16'(16'h1500 + i)), 1'b0);
    chk("pre_reset_fill", 32'(h_fill), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_fill",  32'(h_fill), 32'd0);
    chk("mid_reset_valid", 32'(h_valid), 32'd0);
    chk("mid_reset_data",  h_data, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
